sccb_slave: RTL and testbench
=============================

Name: sccb_slave

Overview:
- SCCB responder: the target end of the team's 3-wire SCCB master, used as a camera-register model in simulation and as an on-FPGA configuration target.
- Oversamples sdioc/sdiod on a fast system clock and decodes start, stop, ID, sub-address and data phases.
- Holds an internal 8-bit register file, publishes write strobes, and returns register contents on read cycles.

Parameters:
- SLAVE_ID, 7'h21, 7-bit ID address this slave answers to.
- REG_DEPTH, 256, number of 8-bit registers; sub-addresses at or above REG_DEPTH are ignored for writes and read back as 8'h00.

Ports:
- clk  in  1  system clock, at least 8x the sdioc frequency
- reset  in  1  synchronous, active-low reset
- sdioc  in  1  SCCB clock from master, idles high
- sdiod  inout  1  SCCB data; driven only during read-data bits, otherwise Z
- wr_strobe  out  1  one-cycle pulse when a data byte is committed
- wr_addr  out  8  sub-address of committed byte
- wr_data  out  8  committed byte
- rd_strobe  out  1  one-cycle pulse when a read byte is launched
- busy  out  1  high from a valid start until stop
- dbg_addr  in  8  side-band register read address
- dbg_data  out  8  register[dbg_addr], registered, 1-cycle latency

Behaviour:
- Reset (reset==0 at posedge clk): all outputs 0, sdiod Z, register file 8'h00, sub-address 8'h00, state IDLE, synchronizers preset to 1.
- Input path: 2-flop synchronizers on sdioc and sdiod, then edge detect; rise/fall events are 3 clk cycles after the pin edge.
- Start: sdiod falls while sdioc is high. From any state, including mid-byte, this sets busy and goes to ID_PH with bit count 0.
- Stop: sdiod rises while sdioc is high. From any state this goes to IDLE, clears busy and releases sdiod. A partial byte is discarded with no strobe.
- Bit sampling: master-driven bits are sampled on sdioc rise. Each phase is 9 bits: 8 information bits MSB first, then 1 don't-care bit. The don't-care bit is ignored, and the slave never drives it in write phases.
- ID_PH: 8 bits are {id[6:0], rw}.
  - id != SLAVE_ID: go to WAIT_STOP.
  - rw==0: go to SUB_PH.
  - rw==1: go to RD_PH.
- SUB_PH: 8 bits are latched as the sub-address, then DAT_PH.
- DAT_PH: first 8 bits form byte b.
  - b == {SLAVE_ID,1'b1}: chained read re-address; go to RD_PH with no write. Limitation: writing that value is impossible.
  - Otherwise, 1 clk after the 8th rise: wr_strobe=1, wr_addr=sub-address, wr_data=b, register[sub-address]<=b. Then WAIT_STOP after the don't-care bit.
- RD_PH:
  - Entered after the 8th rise of the ID byte or chained byte.
  - On the 9th rise (don't-care) the slave drives bit7 of register[sub-address] and pulses rd_strobe.
  - Each following rise launches the next lower bit. The master samples on the sdioc fall in between.
  - bit0 is held until the 17th rise counted from the phase start. The slave then releases sdiod to Z and goes to WAIT_STOP.
  - sdiod is driven 0/1 (not open-drain).
- Read without chaining: a sub-address latched in one transaction persists across stop. Start + ID+R reads the last latched sub-address.
- WAIT_STOP: ignores all bits; exits only on stop or start.
- Reset mid-transaction overrides everything: sdiod Z in the same cycle reset is sampled.
- A write strobe and a dbg read of the same address in the same cycle: dbg_data returns the old value.

Optional Feature:
- Macro: SCCB_SLAVE_AUTOINC_EN.
- With the macro defined:
  - After each committed write byte the sub-address increments (8'hFF wraps to 8'h00) and the slave stays in DAT_PH, so consecutive bytes without stop write successive registers.
  - After each read byte the sub-address increments and RD_PH repeats.
- Without the macro: one data byte per transaction and the sub-address is never modified by data phases.

Decomposition:
- Package sccb_pkg: the state enum (IDLE, ID_PH, SUB_PH, DAT_PH, RD_PH, WAIT_STOP), the phase-length constant 9 and the don't-care bit index 8. The team's master is to adopt the same package.
- Sub-module sccb_line_sync: 2-flop synchronizers plus sdioc_rise, sdioc_fall, start_det and stop_det pulse outputs. Everything else stays in sccb_slave.

Test Plan:
- Write: start, ID 8'h42, sub 8'h12, data 8'hA5, stop -> one wr_strobe with wr_addr 8'h12, wr_data 8'hA5; dbg_addr 8'h12 -> dbg_data 8'hA5 one cycle later.
- Chained read, team-master style (ID 8'h42, sub 8'h12, 8'h43, 9 read clocks, stop) after the write above -> master data_out 8'hA5; rd_strobe once; sdiod Z after the 17th rise; no wr_strobe.
- Split read: ID 8'h42 + sub 8'h12, stop; start, ID 8'h43 -> 8'hA5 returned.
- Wrong ID 8'h60 write of 8'hFF -> no strobes, sdiod never driven, busy drops at stop.
- Stop after 4 data bits of 8'h3C to sub 8'h05 -> no wr_strobe; register 8'h05 stays 8'h00; state IDLE.
- reset driven low during read bit 3 -> sdiod Z next clk, busy 0, dbg_data 8'h00 for address 8'h12; a new write afterwards succeeds.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions for the slave and the team's SCCB master.
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_PH,
    SUB_PH,
    DAT_PH,
    RD_PH,
    WAIT_STOP
  } sccb_state_e;

  localparam int PHASE_LEN = 9;
  localparam int DC_BIT    = 8;

  function automatic logic addr_ok(input logic [7:0] addr, input int unsigned depth);
    return {24'h0, addr} < depth;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes sdioc/sdiod into clk and emits single-cycle bus events,
// three clk edges after the pin change.
module sccb_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic sdioc,
  input  logic sdiod,
  output logic sdiod_s,
  output logic sdioc_rise,
  output logic sdioc_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] are the synchronizer pair, [2] is the edge-detect history
  logic [2:0] c_q;
  logic [2:0] d_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      c_q        <= 3'b111;
      d_q        <= 3'b111;
      sdiod_s    <= 1'b1;
      sdioc_rise <= 1'b0;
      sdioc_fall <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      c_q        <= {c_q[1:0], sdioc};
      d_q        <= {d_q[1:0], sdiod};
      sdiod_s    <= d_q[1];
      sdioc_rise <= c_q[1] & ~c_q[2];
      sdioc_fall <= ~c_q[1] & c_q[2];
      start_det  <= c_q[1] & c_q[2] & d_q[2] & ~d_q[1];
      stop_det   <= c_q[1] & c_q[2] & ~d_q[2] & d_q[1];
    end
  end

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder with 8-bit register file and side-band debug read port.
// SCCB_SLAVE_AUTOINC_EN: auto-increment sub-address on multi-byte writes/reads.
//
// state     | meaning
// IDLE      | bus free, waiting for start
// ID_PH     | shifting {id, rw}
// SUB_PH    | shifting sub-address
// DAT_PH    | shifting write byte (or chained read re-address)
// RD_PH     | driving register bits out
// WAIT_STOP | not addressed / done, waiting for stop or start
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ID  = 7'h21,
  parameter int unsigned REG_DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdioc,
  inout  wire        sdiod,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_strobe,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int AW = $clog2(REG_DEPTH);
  localparam logic [4:0] LAST   = 5'(DC_BIT - 1);
  localparam logic [4:0] DC     = 5'(DC_BIT);
  localparam logic [4:0] RD_END = 5'(2 * PHASE_LEN - 2);

  logic        sdiod_s, sdioc_rise, sdioc_fall, start_det, stop_det;
  sccb_state_e state;
  logic [4:0]  bit_cnt;
  logic [6:0]  sh;
  logic [7:0]  sub_addr;
  logic        drv_en, drv_val;
  logic [6:0]  rd_sh;
  logic        self_mask;
  logic [7:0]  regs [REG_DEPTH];
  logic [7:0]  cur_byte, rd_addr, rd_val;

  sccb_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .sdioc     (sdioc),
    .sdiod     (sdiod),
    .sdiod_s   (sdiod_s),
    .sdioc_rise(sdioc_rise),
    .sdioc_fall(sdioc_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sdiod    = drv_en ? drv_val : 1'bz;
  assign cur_byte = {sh, sdiod_s};
`ifdef SCCB_SLAVE_AUTOINC_EN
  assign rd_addr  = (bit_cnt == RD_END) ? sub_addr + 8'd1 : sub_addr;
`else
  assign rd_addr  = sub_addr;
`endif
  assign rd_val   = addr_ok(rd_addr, REG_DEPTH) ? regs[rd_addr[AW-1:0]] : 8'h00;

  // Our own drive changes happen while sdioc is high; self_mask keeps them
  // from being decoded as start/stop until the clock falls again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      sub_addr  <= '0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_strobe <= 1'b0;
      drv_en    <= 1'b0;
      drv_val   <= 1'b0;
      rd_sh     <= '0;
      self_mask <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      if (sdioc_fall) self_mask <= 1'b0;
      if (stop_det && !self_mask) begin
        state   <= IDLE;
        busy    <= 1'b0;
        drv_en  <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det && !self_mask) begin
        state   <= ID_PH;
        busy    <= 1'b1;
        drv_en  <= 1'b0;
        bit_cnt <= '0;
      end else if (sdioc_rise) begin
        sh <= cur_byte[6:0];
        case (state)
          ID_PH: begin
            if (bit_cnt == LAST) begin
              bit_cnt <= DC;
              if (cur_byte[7:1] != SLAVE_ID) state <= WAIT_STOP;
              else if (cur_byte[0])          state <= RD_PH;
            end else if (bit_cnt == DC) begin
              state   <= SUB_PH;
              bit_cnt <= '0;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          SUB_PH: begin
            if (bit_cnt == LAST) begin
              sub_addr <= cur_byte;
              bit_cnt  <= DC;
            end else if (bit_cnt == DC) begin
              state   <= DAT_PH;
              bit_cnt <= '0;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          DAT_PH: begin
            if (bit_cnt == LAST) begin
              bit_cnt <= DC;
              if (cur_byte == {SLAVE_ID, 1'b1}) state <= RD_PH;
              else begin
                wr_strobe <= addr_ok(sub_addr, REG_DEPTH);
                wr_addr   <= sub_addr;
                wr_data   <= cur_byte;
`ifdef SCCB_SLAVE_AUTOINC_EN
                sub_addr  <= sub_addr + 8'd1;
`endif
              end
            end else if (bit_cnt == DC) begin
`ifdef SCCB_SLAVE_AUTOINC_EN
              bit_cnt <= '0;
`else
              state   <= WAIT_STOP;
`endif
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          RD_PH: begin
            self_mask <= 1'b1;
            if (bit_cnt == RD_END) begin
`ifdef SCCB_SLAVE_AUTOINC_EN
              sub_addr  <= rd_addr;
              drv_val   <= rd_val[7];
              rd_sh     <= rd_val[6:0];
              rd_strobe <= 1'b1;
              bit_cnt   <= DC + 5'd1;
`else
              drv_en    <= 1'b0;
              state     <= WAIT_STOP;
`endif
            end else if (bit_cnt == DC) begin
              drv_en    <= 1'b1;
              drv_val   <= rd_val[7];
              rd_sh     <= rd_val[6:0];
              rd_strobe <= 1'b1;
              bit_cnt   <= bit_cnt + 5'd1;
            end else begin
              drv_val <= rd_sh[6];
              rd_sh   <= {rd_sh[5:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Write lands on the edge closing the strobe cycle, so a same-cycle dbg read sees the old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs     <= '{default: 8'h00};
      dbg_data <= 8'h00;
    end else begin
      if (wr_strobe) regs[wr_addr[AW-1:0]] <= wr_data;
      dbg_data <= addr_ok(dbg_addr, REG_DEPTH) ? regs[dbg_addr[AW-1:0]] : 8'h00;
    end
  end

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bit-level SCCB master with pull-up on sdiod.
module tb_sccb_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       sdioc;
  wire        sdiod;
  logic       wr_strobe, rd_strobe, busy;
  logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;
  logic       m_oe, m_val;

  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int low_seen = 0;
  logic [7:0] last_wa, last_wd, dbg_after_wr;
  bit wr_pend = 0;

  assign sdiod = m_oe ? m_val : 1'bz;
  pullup (sdiod);

  always #5 clk = ~clk;

  sccb_slave dut (
    .clk      (clk),
    .reset    (reset),
    .sdioc    (sdioc),
    .sdiod    (sdiod),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_strobe(rd_strobe),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always @(negedge clk) begin
    if (wr_pend) dbg_after_wr = dbg_data;
    wr_pend = wr_strobe;
    if (wr_strobe) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_strobe) rd_cnt++;
    if (!m_oe && sdiod === 1'b0) low_seen++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    m_oe = 1'b1; m_val = b;
    wait_clks(4); sdioc = 1'b1;
    wait_clks(8); sdioc = 1'b0;
    wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (dc) begin
      m_oe = 1'b0;
      wait_clks(4); sdioc = 1'b1;
      wait_clks(8); sdioc = 1'b0;
      wait_clks(4);
    end
  endtask

  task automatic read9(output logic [7:0] d);
    d = 8'h00;
    m_oe = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_clks(4); sdioc = 1'b1;
      wait_clks(8); sdioc = 1'b0;
      if (i < 8) d = {d[6:0], sdiod};
      wait_clks(4);
    end
  endtask

  task automatic bus_start();
    m_oe = 1'b1; m_val = 1'b1; sdioc = 1'b1;
    wait_clks(4); m_val = 1'b0;
    wait_clks(8); sdioc = 1'b0;
    wait_clks(4);
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; m_val = 1'b0;
    wait_clks(4); sdioc = 1'b1;
    wait_clks(8); m_val = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_reset();
    reset = 1'b0; sdioc = 1'b1; m_oe = 1'b1; m_val = 1'b1; dbg_addr = 8'h12;
    wait_clks(3);
    m_oe = 1'b0;
    wait_clks(1);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (wr_strobe !== 1'b0) begin err_cnt++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    vec_cnt++; if (rd_strobe !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_strobe: got %b want 0", rd_strobe); end
    vec_cnt++; if (wr_addr !== 8'h00) begin err_cnt++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    vec_cnt++; if (wr_data !== 8'h00) begin err_cnt++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    vec_cnt++; if (dbg_data !== 8'h00) begin err_cnt++; $display("FAIL reset_dbg_data: got %h want 00", dbg_data); end
    vec_cnt++; if (sdiod !== 1'b1) begin err_cnt++; $display("FAIL reset_sdiod_released: got %b want 1", sdiod); end
    m_oe = 1'b1;
    reset = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cnt;
    dbg_addr = 8'h12;
    bus_start();
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wr_busy_after_start: got %b want 1", busy); end
    send_byte(8'h42, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'hA5, 1'b1);
    bus_stop();
    vec_cnt++; if (wr_cnt - w0 !== 1) begin err_cnt++; $display("FAIL wr_strobe_count: got %0d want 1", wr_cnt - w0); end
    vec_cnt++; if (last_wa !== 8'h12) begin err_cnt++; $display("FAIL wr_addr: got %h want 12", last_wa); end
    vec_cnt++; if (last_wd !== 8'hA5) begin err_cnt++; $display("FAIL wr_data: got %h want a5", last_wd); end
    vec_cnt++; if (dbg_after_wr !== 8'h00) begin err_cnt++; $display("FAIL dbg_same_cycle_old: got %h want 00", dbg_after_wr); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
    dbg_addr = 8'h12;
    wait_clks(2);
    vec_cnt++; if (dbg_data !== 8'hA5) begin err_cnt++; $display("FAIL wr_dbg_readback: got %h want a5", dbg_data); end
  endtask

  task automatic test_chain_read();
    int w0, r0;
    logic [7:0] d;
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h43, 1'b0);
    read9(d);
    vec_cnt++; if (sdiod !== 1'b1) begin err_cnt++; $display("FAIL chain_sdiod_released: got %b want 1", sdiod); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL chain_busy: got %b want 1", busy); end
    bus_stop();
    vec_cnt++; if (d !== 8'hA5) begin err_cnt++; $display("FAIL chain_read_data: got %h want a5", d); end
    vec_cnt++; if (rd_cnt - r0 !== 1) begin err_cnt++; $display("FAIL chain_rd_strobe_count: got %0d want 1", rd_cnt - r0); end
    vec_cnt++; if (wr_cnt - w0 !== 0) begin err_cnt++; $display("FAIL chain_no_write: got %0d want 0", wr_cnt - w0); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL chain_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_split_read();
    int w0;
    logic [7:0] d;
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h12, 1'b1);
    bus_stop();
    bus_start();
    send_byte(8'h43, 1'b0);
    read9(d);
    bus_stop();
    vec_cnt++; if (d !== 8'hA5) begin err_cnt++; $display("FAIL split_read_data: got %h want a5", d); end
    vec_cnt++; if (wr_cnt - w0 !== 0) begin err_cnt++; $display("FAIL split_no_write: got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_wrong_id();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt; low_seen = 0;
    bus_start();
    send_byte(8'h60, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'hFF, 1'b1);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wid_busy: got %b want 1", busy); end
    bus_stop();
    vec_cnt++; if (wr_cnt - w0 !== 0) begin err_cnt++; $display("FAIL wid_no_wr_strobe: got %0d want 0", wr_cnt - w0); end
    vec_cnt++; if (rd_cnt - r0 !== 0) begin err_cnt++; $display("FAIL wid_no_rd_strobe: got %0d want 0", rd_cnt - r0); end
    vec_cnt++; if (low_seen !== 0) begin err_cnt++; $display("FAIL wid_sdiod_driven: got %0d low samples want 0", low_seen); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wid_busy_after_stop: got %b want 0", busy); end
    dbg_addr = 8'h12;
    wait_clks(2);
    vec_cnt++; if (dbg_data !== 8'hA5) begin err_cnt++; $display("FAIL wid_reg_unchanged: got %h want a5", dbg_data); end
  endtask

  task automatic test_partial_stop();
    int w0;
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h05, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_stop();
    vec_cnt++; if (wr_cnt - w0 !== 0) begin err_cnt++; $display("FAIL partial_no_wr_strobe: got %0d want 0", wr_cnt - w0); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL partial_busy: got %b want 0", busy); end
    dbg_addr = 8'h05;
    wait_clks(2);
    vec_cnt++; if (dbg_data !== 8'h00) begin err_cnt++; $display("FAIL partial_reg05: got %h want 00", dbg_data); end
  endtask

  task automatic test_reset_mid_read();
    int w0;
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h43, 1'b0);
    m_oe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_clks(4); sdioc = 1'b1;
      wait_clks(8); sdioc = 1'b0;
      wait_clks(4);
    end
    wait_clks(4); sdioc = 1'b1;
    wait_clks(8);
    vec_cnt++; if (sdiod !== 1'b0) begin err_cnt++; $display("FAIL rst_bit3_driven: got %b want 0", sdiod); end
    reset = 1'b0;
    wait_clks(1);
    vec_cnt++; if (sdiod !== 1'b1) begin err_cnt++; $display("FAIL rst_sdiod_released: got %b want 1", sdiod); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
    m_oe = 1'b1; m_val = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    dbg_addr = 8'h12;
    wait_clks(3);
    vec_cnt++; if (dbg_data !== 8'h00) begin err_cnt++; $display("FAIL rst_reg_cleared: got %h want 00", dbg_data); end
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h77, 1'b1);
    bus_stop();
    vec_cnt++; if (wr_cnt - w0 !== 1) begin err_cnt++; $display("FAIL rst_new_write_count: got %0d want 1", wr_cnt - w0); end
    vec_cnt++; if (last_wd !== 8'h77) begin err_cnt++; $display("FAIL rst_new_write_data: got %h want 77", last_wd); end
    wait_clks(2);
    vec_cnt++; if (dbg_data !== 8'h77) begin err_cnt++; $display("FAIL rst_new_write_readback: got %h want 77", dbg_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_chain_read();
    test_split_read();
    test_wrong_id();
    test_partial_stop();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
